bus_xfer_ctrl: RTL and testbench
================================

BUS_XFER_CTRL -- requirements
Module: bus_xfer_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the shared bus width.
REQ-002 The block SHALL have parameter NUM_REG, default 8, giving the number of bus registers served.
REQ-003 The block SHALL have parameter IDX_W, default 3, giving the register index width (clog2 of NUM_REG).
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 clr  input  1  reset, synchronous and active-high.
REQ-006 req_valid  input  1  transfer request present.
REQ-007 req_ready  output  1  controller can accept a request this cycle.
REQ-008 req_src  input  IDX_W  index of the source register (the one that drives the bus).
REQ-009 req_dst  input  IDX_W  index of the destination register (the one that loads from the bus).
REQ-010 req_imm  input  1  1 = the controller drives req_data onto the bus instead of a source register.
REQ-011 req_data  input  DATA_W  immediate value, used only when req_imm=1.
REQ-012 rd_en  output  NUM_REG  one-hot source enable; the selected register drives the bus.
REQ-013 wr_en  output  NUM_REG  one-hot destination enable; the selected register loads from the bus on the rising edge.
REQ-014 bus  inout  DATA_W  shared tri-state data bus.
REQ-015 last_data  output  DATA_W  bus value captured on the most recent completed transfer.
REQ-016 done  output  1  one-cycle pulse marking a completed transfer.
REQ-017 err  output  1  one-cycle pulse marking a rejected request.

Function
REQ-018 The FSM SHALL use the states IDLE, SETUP, XFER, DONE and ERR.
REQ-019 req_ready SHALL be 1 only in IDLE and only when clr=0; a request is accepted on a rising edge with req_valid=1 and req_ready=1.
REQ-020 On acceptance the block SHALL register req_src, req_dst, req_imm and req_data; later input changes SHALL have no effect on the transfer in progress.
REQ-021 Accepting a request with req_imm=0 and req_src==req_dst SHALL cause IDLE->ERR; every other accepted request SHALL cause IDLE->SETUP.
REQ-022 In ERR, err=1, all enables SHALL be 0, the bus SHALL be released, and the next state SHALL be IDLE; last_data SHALL be unchanged.
REQ-023 In SETUP (bus settle cycle):
- req_imm=0: rd_en[src]=1.
- req_imm=1: rd_en=0 and the controller drives the registered req_data.
- wr_en=0.
- Next state: XFER.
REQ-024 In XFER, the SETUP source and drive conditions SHALL hold, with the addition of wr_en[dst]=1 (this applies even when req_imm=1 and src==dst); next state: DONE.
REQ-025 On the rising edge that ends XFER, last_data SHALL load the bus value.
REQ-026 In DONE, done=1, rd_en=0, wr_en=0, the bus SHALL be released, and the next state SHALL be IDLE.
REQ-027 Latency: done SHALL be high exactly in the 3rd cycle after the acceptance edge, and req_ready SHALL return to 1 in the 4th cycle, giving a maximum of one transfer per 4 cycles.
REQ-028 The controller SHALL drive the bus only in SETUP and XFER of an immediate transfer and SHALL drive 'z' at all other times.
REQ-029 At most one bus driver SHALL be enabled at any time: rd_en SHALL be 0 whenever the controller drives the bus, and rd_en and wr_en SHALL each be zero-or-one-hot.
REQ-030 An index >= NUM_REG SHALL be treated as an error: the block goes to ERR with no enable asserted.
REQ-031 done and err SHALL never both be 1 in the same cycle.

Reset
REQ-032 While clr=1 at a rising edge, the next state SHALL be IDLE and the registered request SHALL be cleared.
REQ-033 After that edge the outputs SHALL be: rd_en=0, wr_en=0, bus='z', last_data=0, done=0, err=0.
REQ-034 req_ready SHALL be 0 while clr=1.
REQ-035 A clr asserted in SETUP, XFER or DONE SHALL abort the transfer with no done pulse, and last_data SHALL read 0.
REQ-036 The first request SHALL be accepted on the first rising edge with clr=0 and req_valid=1.

Verification
REQ-037 Reset: hold clr=1 for 2 cycles -> req_ready=0, enables 0, bus z, last_data=0; after release, req_ready=1.
REQ-038 Register move: src=2 driving 8'hC5, dst=5, imm=0 -> cycle+1 rd_en=8'h04, wr_en=0; cycle+2 rd_en=8'h04, wr_en=8'h20; cycle+3 done=1, last_data=8'hC5, register 5 holds 8'hC5.
REQ-039 Immediate load: imm=1, data=8'h8E, dst=0 -> bus=8'h8E in SETUP/XFER with rd_en=0, wr_en=8'h01 in XFER; done=1, last_data=8'h8E; bus z in DONE.
REQ-040 Error: imm=0, src=dst=3 -> next cycle err=1, no enable asserted, last_data unchanged, req_ready=1 the cycle after.
REQ-041 Reset mid-transfer: assert clr in XFER -> next cycle IDLE, enables 0, bus z, no done pulse, last_data=0.
REQ-042 Back-to-back: req_valid held at 1 with two queued requests -> second accepted exactly 4 cycles after the first, with no overlapping enables.

Source files
------------

// File: rtl/bus_xfer_ctrl.sv
// Purpose: sequences one register-to-register or immediate-to-register move over a shared tri-state bus.
// Latency: done pulses in the 3rd cycle after the acceptance edge; the next request is accepted in the 4th.
// Backpressure: req_ready is high only in IDLE with clr low; a held request waits until the controller is idle.
module bus_xfer_ctrl #(
    parameter int DATA_W  = 8,
    parameter int NUM_REG = 8,
    parameter int IDX_W   = 3
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [IDX_W-1:0]   req_src,
    input  logic [IDX_W-1:0]   req_dst,
    input  logic               req_imm,
    input  logic [DATA_W-1:0]  req_data,
    output logic [NUM_REG-1:0] rd_en,
    output logic [NUM_REG-1:0] wr_en,
    inout  wire  [DATA_W-1:0]  bus,
    output logic [DATA_W-1:0]  last_data,
    output logic               done,
    output logic               err
);

    typedef enum logic [2:0] {IDLE, SETUP, XFER, DONE, ERR} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     src_q, src_d;
    logic [IDX_W-1:0]     dst_q, dst_d;
    logic                 imm_q, imm_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [DATA_W-1:0]    last_data_q, last_data_d;
    logic [NUM_REG-1:0]   rd_en_q, rd_en_d;
    logic [NUM_REG-1:0]   wr_en_q, wr_en_d;
    logic                 drv_q, drv_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 accept;
    logic                 bad_idx;

    function automatic logic [NUM_REG-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REG-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign req_ready = (state_q == IDLE) && !clr;
    assign accept    = req_valid && req_ready;

    // The source index is irrelevant for immediates, so only the destination is range-checked then.
    assign bad_idx = (32'(req_dst) >= NUM_REG) || (!req_imm && (32'(req_src) >= NUM_REG));

    // Next state, request capture, and registered outputs decoded from the state being entered.
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        imm_d       = imm_q;
        data_d      = data_q;
        last_data_d = last_data_q;
        rd_en_d     = '0;
        wr_en_d     = '0;
        drv_d       = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    src_d  = req_src;
                    dst_d  = req_dst;
                    imm_d  = req_imm;
                    data_d = req_data;
                    if (bad_idx || (!req_imm && (req_src == req_dst))) begin
                        state_d = ERR;
                    end else begin
                        state_d = SETUP;
                    end
                end
            end
            SETUP:   state_d = XFER;
            XFER: begin
                // The destination loads on this same edge, so last_data mirrors what it stored.
                last_data_d = bus;
                state_d     = DONE;
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        case (state_d)
            SETUP: begin
                if (imm_d) drv_d = 1'b1;
                else       rd_en_d = onehot(src_d);
            end
            XFER: begin
                if (imm_d) drv_d = 1'b1;
                else       rd_en_d = onehot(src_d);
                wr_en_d = onehot(dst_d);
            end
            DONE:    done_d = 1'b1;
            ERR:     err_d  = 1'b1;
            default: ;
        endcase
    end

    // State and output registers; clr wipes the captured request and any in-flight transfer.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            imm_q       <= 1'b0;
            data_q      <= '0;
            last_data_q <= '0;
            rd_en_q     <= '0;
            wr_en_q     <= '0;
            drv_q       <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            imm_q       <= imm_d;
            data_q      <= data_d;
            last_data_q <= last_data_d;
            rd_en_q     <= rd_en_d;
            wr_en_q     <= wr_en_d;
            drv_q       <= drv_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus       = drv_q ? data_q : {DATA_W{1'bz}};
    assign rd_en     = rd_en_q;
    assign wr_en     = wr_en_q;
    assign last_data = last_data_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Bench for bus_xfer_ctrl: a behavioural register file sits on the bus, and a transfer-level
// model (expected register contents plus last captured value) predicts every outcome.
// Inputs change 1 time unit after the rising edge; outputs are observed at that same point.
module tb_bus_xfer_ctrl;
    localparam int DW = 8;
    localparam int NR = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_imm = 1'b0;
    logic [IW-1:0] req_src = '0;
    logic [IW-1:0] req_dst = '0;
    logic [DW-1:0] req_data = '0;
    logic          req_ready, done, err;
    logic [NR-1:0] rd_en, wr_en;
    logic [DW-1:0] last_data;
    wire  [DW-1:0] bus;
    logic          park = 1'b0;

    logic [DW-1:0] regs     [NR];
    logic [DW-1:0] init_val [NR];
    logic [DW-1:0] exp_regs [NR];
    logic [DW-1:0] exp_last;
    int            tests = 0;
    int            fails = 0;
    int            rd_idx;

    always #5 clk = ~clk;

    bus_xfer_ctrl #(.DATA_W(DW), .NUM_REG(NR), .IDX_W(IW)) dut (
        .clk(clk), .clr(clr), .req_valid(req_valid), .req_ready(req_ready),
        .req_src(req_src), .req_dst(req_dst), .req_imm(req_imm), .req_data(req_data),
        .rd_en(rd_en), .wr_en(wr_en), .bus(bus), .last_data(last_data),
        .done(done), .err(err)
    );

    // Register file on the bus; park drives a sentinel so a released bus reads 8'h5A.
    always_comb begin
        rd_idx = 0;
        for (int i = 0; i < NR; i++) if (rd_en[i]) rd_idx = i;
    end
    assign bus = (rd_en != '0) ? regs[rd_idx] : (park ? 8'h5A : {DW{1'bz}});

    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (clr)           regs[i] <= init_val[i];
            else if (wr_en[i]) regs[i] <= bus;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        repeat (2) step();
        park = 1'b1; #1;
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", req_ready); end
        tests++; if (rd_en !== 8'h00) begin fails++; $display("FAIL reset_rd_en: got %h want 00", rd_en); end
        tests++; if (wr_en !== 8'h00) begin fails++; $display("FAIL reset_wr_en: got %h want 00", wr_en); end
        tests++; if (bus !== 8'h5A) begin fails++; $display("FAIL reset_bus_released: got %h want 5a", bus); end
        tests++; if (last_data !== 8'h00) begin fails++; $display("FAIL reset_last_data: got %h want 00", last_data); end
        tests++; if ({done, err} !== 2'b00) begin fails++; $display("FAIL reset_done_err: got %b want 00", {done, err}); end
        park = 1'b0;
        clr  = 1'b0; #1;
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_reg_move();
        req_src = 3'd2; req_dst = 3'd5; req_imm = 1'b0; req_data = 8'hFF; req_valid = 1'b1;
        step();
        req_valid = 1'b0; req_src = 3'd7; req_dst = 3'd7; req_imm = 1'b1; req_data = 8'h00;
        tests++; if (rd_en !== 8'h04) begin fails++; $display("FAIL move_setup_rd: got %h want 04", rd_en); end
        tests++; if (wr_en !== 8'h00) begin fails++; $display("FAIL move_setup_wr: got %h want 00", wr_en); end
        tests++; if (bus !== 8'hC5) begin fails++; $display("FAIL move_setup_bus: got %h want c5", bus); end
        step();
        tests++; if (rd_en !== 8'h04) begin fails++; $display("FAIL move_xfer_rd: got %h want 04", rd_en); end
        tests++; if (wr_en !== 8'h20) begin fails++; $display("FAIL move_xfer_wr: got %h want 20", wr_en); end
        step();
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL move_done: got %b want 1", done); end
        tests++; if (last_data !== 8'hC5) begin fails++; $display("FAIL move_last_data: got %h want c5", last_data); end
        tests++; if (regs[5] !== 8'hC5) begin fails++; $display("FAIL move_reg5: got %h want c5", regs[5]); end
        tests++; if ({rd_en, wr_en} !== 16'h0) begin fails++; $display("FAIL move_done_en: got %h want 0000", {rd_en, wr_en}); end
        exp_regs[5] = 8'hC5; exp_last = 8'hC5;
        step();
        tests++; if ({req_ready, done} !== 2'b10) begin fails++; $display("FAIL move_ready_back: got %b want 10", {req_ready, done}); end
    endtask

    task automatic test_imm_load();
        req_src = 3'd0; req_dst = 3'd0; req_imm = 1'b1; req_data = 8'h8E; req_valid = 1'b1;
        step();
        req_valid = 1'b0; req_data = 8'h11; req_imm = 1'b0;
        tests++; if (bus !== 8'h8E) begin fails++; $display("FAIL imm_setup_bus: got %h want 8e", bus); end
        tests++; if ({rd_en, wr_en} !== 16'h0) begin fails++; $display("FAIL imm_setup_en: got %h want 0000", {rd_en, wr_en}); end
        step();
        tests++; if (bus !== 8'h8E) begin fails++; $display("FAIL imm_xfer_bus: got %h want 8e", bus); end
        tests++; if (rd_en !== 8'h00) begin fails++; $display("FAIL imm_xfer_rd: got %h want 00", rd_en); end
        tests++; if (wr_en !== 8'h01) begin fails++; $display("FAIL imm_xfer_wr: got %h want 01", wr_en); end
        step();
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL imm_done: got %b want 1", done); end
        tests++; if (last_data !== 8'h8E) begin fails++; $display("FAIL imm_last_data: got %h want 8e", last_data); end
        tests++; if (regs[0] !== 8'h8E) begin fails++; $display("FAIL imm_reg0: got %h want 8e", regs[0]); end
        park = 1'b1; #1;
        tests++; if (bus !== 8'h5A) begin fails++; $display("FAIL imm_done_bus_released: got %h want 5a", bus); end
        park = 1'b0;
        exp_regs[0] = 8'h8E; exp_last = 8'h8E;
        step();
    endtask

    task automatic test_error();
        req_src = 3'd3; req_dst = 3'd3; req_imm = 1'b0; req_data = 8'h77; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        tests++; if ({err, done} !== 2'b10) begin fails++; $display("FAIL err_pulse: got err,done=%b want 10", {err, done}); end
        tests++; if ({rd_en, wr_en} !== 16'h0) begin fails++; $display("FAIL err_enables: got %h want 0000", {rd_en, wr_en}); end
        tests++; if (last_data !== exp_last) begin fails++; $display("FAIL err_last_data: got %h want %h", last_data, exp_last); end
        park = 1'b1; #1;
        tests++; if (bus !== 8'h5A) begin fails++; $display("FAIL err_bus_released: got %h want 5a", bus); end
        park = 1'b0;
        step();
        tests++; if ({req_ready, err} !== 2'b10) begin fails++; $display("FAIL err_ready_back: got %b want 10", {req_ready, err}); end
    endtask

    task automatic test_reset_mid();
        req_src = 3'd1; req_dst = 3'd6; req_imm = 1'b0; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        tests++; if (wr_en !== 8'h40) begin fails++; $display("FAIL mid_xfer_wr: got %h want 40", wr_en); end
        clr = 1'b1;
        step();
        tests++; if ({rd_en, wr_en} !== 16'h0) begin fails++; $display("FAIL mid_enables: got %h want 0000", {rd_en, wr_en}); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL mid_no_done: got %b want 0", done); end
        tests++; if (last_data !== 8'h00) begin fails++; $display("FAIL mid_last_data: got %h want 00", last_data); end
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL mid_ready_in_clr: got %b want 0", req_ready); end
        park = 1'b1; #1;
        tests++; if (bus !== 8'h5A) begin fails++; $display("FAIL mid_bus_released: got %h want 5a", bus); end
        park = 1'b0;
        clr = 1'b0;
        step();
        tests++; if ({req_ready, done} !== 2'b10) begin fails++; $display("FAIL mid_after_release: got %b want 10", {req_ready, done}); end
        for (int i = 0; i < NR; i++) exp_regs[i] = init_val[i];
        exp_last = 8'h00;
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] a_val;
        logic [DW-1:0] b_dat;
        int            ready_at;
        a_val = exp_regs[4];
        b_dat = 8'($urandom_range(0, 255));
        ready_at = -1;
        req_src = 3'd4; req_dst = 3'd1; req_imm = 1'b0; req_valid = 1'b1;
        step();
        req_src = 3'd2; req_dst = 3'd7; req_imm = 1'b1; req_data = b_dat;
        for (int k = 1; k <= 4; k++) begin
            tests++; if (((rd_en & (rd_en - 8'd1)) | (wr_en & (wr_en - 8'd1))) !== 8'h00) begin
                fails++; $display("FAIL b2b_onehot cycle %0d: got rd=%h wr=%h want zero-or-one-hot", k, rd_en, wr_en);
            end
            tests++; if (done !== (k == 3)) begin fails++; $display("FAIL b2b_done cycle %0d: got %b want %b", k, done, (k == 3)); end
            if (k == 3) begin
                tests++; if (last_data !== a_val) begin fails++; $display("FAIL b2b_first_last: got %h want %h", last_data, a_val); end
            end
            if (req_ready === 1'b1 && ready_at < 0) ready_at = k;
            if (k < 4) step();
        end
        tests++; if (ready_at != 4) begin fails++; $display("FAIL b2b_accept_gap: got %0d want 4", ready_at); end
        exp_regs[1] = a_val;
        step();
        req_valid = 1'b0;
        tests++; if ({rd_en, wr_en} !== 16'h0 || bus !== b_dat) begin
            fails++; $display("FAIL b2b_second_setup: got en=%h bus=%h want 0000/%h", {rd_en, wr_en}, bus, b_dat);
        end
        step();
        tests++; if (wr_en !== 8'h80) begin fails++; $display("FAIL b2b_second_wr: got %h want 80", wr_en); end
        step();
        tests++; if ({done, last_data} !== {1'b1, b_dat}) begin
            fails++; $display("FAIL b2b_second_done: got %b/%h want 1/%h", done, last_data, b_dat);
        end
        exp_regs[7] = b_dat; exp_last = b_dat;
        step();
    endtask

    task automatic test_random();
        logic [IW-1:0] s, d;
        logic          im, is_err;
        logic [DW-1:0] dat, val, exp_rd;
        int            waitc;
        for (int n = 0; n < 24; n++) begin
            s   = 3'($urandom_range(0, 7));
            d   = 3'($urandom_range(0, 7));
            im  = 1'($urandom_range(0, 1));
            dat = 8'($urandom_range(0, 255));
            if (n % 5 == 0) d = s;
            is_err = !im && (s == d);
            val    = im ? dat : exp_regs[s];
            exp_rd = im ? 8'h00 : 8'(1 << s);
            waitc  = 0;
            while (req_ready !== 1'b1 && waitc < 8) begin step(); waitc++; end
            tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rand_ready %0d: got %b want 1", n, req_ready); end
            req_src = s; req_dst = d; req_imm = im; req_data = dat; req_valid = 1'b1;
            step();
            req_valid = 1'b0;
            req_src = 3'($urandom_range(0, 7)); req_dst = 3'($urandom_range(0, 7));
            req_imm = 1'($urandom_range(0, 1)); req_data = 8'($urandom_range(0, 255));
            if (is_err) begin
                tests++; if ({err, done, rd_en, wr_en} !== {2'b10, 16'h0}) begin
                    fails++; $display("FAIL rand_err %0d: got err=%b done=%b en=%h want 1/0/0000", n, err, done, {rd_en, wr_en});
                end
                tests++; if (last_data !== exp_last) begin fails++; $display("FAIL rand_err_last %0d: got %h want %h", n, last_data, exp_last); end
                step();
            end else begin
                tests++; if ({rd_en, wr_en, bus} !== {exp_rd, 8'h00, val} || err !== 1'b0) begin
                    fails++; $display("FAIL rand_setup %0d: got rd=%h wr=%h bus=%h err=%b want %h/00/%h/0", n, rd_en, wr_en, bus, err, exp_rd, val);
                end
                step();
                tests++; if ({rd_en, wr_en, bus} !== {exp_rd, 8'(1 << d), val}) begin
                    fails++; $display("FAIL rand_xfer %0d: got rd=%h wr=%h bus=%h want %h/%h/%h", n, rd_en, wr_en, bus, exp_rd, 8'(1 << d), val);
                end
                step();
                tests++; if ({done, err, last_data} !== {2'b10, val}) begin
                    fails++; $display("FAIL rand_done %0d: got done=%b err=%b last=%h want 1/0/%h", n, done, err, last_data, val);
                end
                tests++; if (regs[d] !== val) begin fails++; $display("FAIL rand_dst %0d: got reg%0d=%h want %h", n, d, regs[d], val); end
                park = 1'b1; #1;
                tests++; if ({rd_en, wr_en, bus} !== {16'h0, 8'h5A}) begin
                    fails++; $display("FAIL rand_release %0d: got en=%h bus=%h want 0000/5a", n, {rd_en, wr_en}, bus);
                end
                park = 1'b0;
                exp_regs[d] = val; exp_last = val;
                step();
            end
            repeat ($urandom_range(0, 2)) step();
        end
    endtask

    initial begin
        for (int i = 0; i < NR; i++) init_val[i] = 8'($urandom_range(0, 255));
        init_val[2] = 8'hC5;
        init_val[5] = 8'h3C;
        for (int i = 0; i < NR; i++) exp_regs[i] = init_val[i];
        exp_last = 8'h00;
        test_reset();
        test_reg_move();
        test_imm_load();
        test_error();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
